// File: rtl/ks_stream_accumulator_pkg.sv
// Shared definitions for the ks_* stream blocks: data width, default counter width
// and the accumulator FSM state encoding.
package ks_stream_accumulator_pkg;

    localparam int DATA_W          = 16;
    localparam int DEFAULT_COUNT_W = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/ks_stream_accumulator_kogge_stone.sv
// 16-bit Kogge-Stone parallel-prefix adder without carry-in.
// Produces the sum and the carry out of bit 15.
module Kogge_Stone
    import ks_stream_accumulator_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s,
    output logic              carry
);

    localparam int STAGES = $clog2(DATA_W);

    logic [STAGES:0][DATA_W-1:0] g;
    logic [STAGES:0][DATA_W-1:0] p;

    // Each stage doubles the span of the group generate/propagate; the low bits
    // that have no partner at this distance pass through unchanged.
    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        for (int k = 0; k < STAGES; k++) begin
            g[k+1] = g[k] | (p[k] & (g[k] << (1 << k)));
            p[k+1] = p[k] & ((p[k] << (1 << k)) | DATA_W'((1 << (1 << k)) - 1));
        end
    end

    assign s     = p[0] ^ {g[STAGES][DATA_W-2:0], 1'b0};
    assign carry = g[STAGES][DATA_W-1];

endmodule

// File: rtl/ks_stream_accumulator.sv
// Packet accumulator: sums 16-bit words through the Kogge-Stone adder and emits one
// result per packet (sum mod 2^16, saturating carry count, saturating word count).
module ks_stream_accumulator
    import ks_stream_accumulator_pkg::*;
#(
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sum,
    output logic [COUNT_W-1:0] out_ovf_count,
    output logic [COUNT_W-1:0] out_word_count
);

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [COUNT_W-1:0] ovf;
    logic [COUNT_W-1:0] cnt;
    logic [DATA_W-1:0]  sum_s;
    logic               carry;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                   input logic en);
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    Kogge_Stone u_adder (
        .a     (acc),
        .b     (in_data),
        .s     (sum_s),
        .carry (carry)
    );

    // in_ready and out_valid are registered alongside the state so both handshakes
    // come straight from flops; the last beat folds its own carry and count into
    // the result while the running registers clear for the next packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_ACCUM;
            acc            <= '0;
            ovf            <= '0;
            cnt            <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            out_sum        <= '0;
            out_ovf_count  <= '0;
            out_word_count <= '0;
        end else if (state == ST_ACCUM) begin
            if (in_valid && in_ready) begin
                if (in_last) begin
                    out_sum        <= sum_s;
                    out_ovf_count  <= sat_inc(ovf, carry);
                    out_word_count <= sat_inc(cnt, 1'b1);
                    acc            <= '0;
                    ovf            <= '0;
                    cnt            <= '0;
                    state          <= ST_HOLD;
                    in_ready       <= 1'b0;
                    out_valid      <= 1'b1;
                end else begin
                    acc <= sum_s;
                    ovf <= sat_inc(ovf, carry);
                    cnt <= sat_inc(cnt, 1'b1);
                end
            end
        end else begin
            if (out_valid && out_ready) begin
                state     <= ST_ACCUM;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ks_stream_accumulator.sv
// Randomized and directed bench for ks_stream_accumulator against a plain-arithmetic
// packet model.
module tb_ks_stream_accumulator;

    localparam int COUNT_W = 8;
    localparam int CNT_MAX = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_sum;
    logic [COUNT_W-1:0] out_ovf_count;
    logic [COUNT_W-1:0] out_word_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] pkt_words[$];
    int exp_sum;
    int exp_ovf;
    int exp_cnt;

    ks_stream_accumulator #(.COUNT_W(COUNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sum        (out_sum),
        .out_ovf_count  (out_ovf_count),
        .out_word_count (out_word_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the packet sum as a wide integer, reduced mod 2^16; a carry is any
    // beat where the running 16-bit total plus the word reaches 2^16.
    task automatic modelPacket();
        int running = 0;
        int carries = 0;
        foreach (pkt_words[i]) begin
            if (running + int'(pkt_words[i]) >= 65536) carries++;
            running = (running + int'(pkt_words[i])) % 65536;
        end
        exp_sum = running;
        exp_ovf = (carries > CNT_MAX) ? CNT_MAX : carries;
        exp_cnt = (pkt_words.size() > CNT_MAX) ? CNT_MAX : pkt_words.size();
    endtask

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input int gap);
        for (int i = 0; i < pkt_words.size(); i++) begin
            waitReady();
            in_valid = 1'b1;
            in_data  = pkt_words[i];
            in_last  = (i == pkt_words.size() - 1);
            @(negedge clk);
            if (gap > 0 && i != pkt_words.size() - 1) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 16'hDEAD;
                repeat (gap) begin
                    checkOutput("gap_in_ready", in_ready, 1);
                    checkOutput("gap_out_valid", out_valid, 0);
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkResult(input string tag, input int hold);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_sum"}, out_sum, exp_sum);
        checkOutput({tag, "_ovf"}, out_ovf_count, exp_ovf);
        checkOutput({tag, "_cnt"}, out_word_count, exp_cnt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput({tag, "_hold_ready"}, in_ready, 0);
            checkOutput({tag, "_hold_valid"}, out_valid, 1);
            checkOutput({tag, "_hold_sum"}, out_sum, exp_sum);
            checkOutput({tag, "_hold_ovf"}, out_ovf_count, exp_ovf);
            checkOutput({tag, "_hold_cnt"}, out_word_count, exp_cnt);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_accepted_valid"}, out_valid, 0);
        checkOutput({tag, "_accepted_ready"}, in_ready, 1);
    endtask

    task automatic runPacket(input string tag, input int gap, input int hold);
        modelPacket();
        applyStimulus(gap);
        checkResult(tag, hold);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #2;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_ready", in_ready, 1);
        checkOutput("reset_sum", out_sum, 0);
        checkOutput("reset_ovf", out_ovf_count, 0);
        checkOutput("reset_cnt", out_word_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        pkt_words = '{16'h1234};
        runPacket("single", 0, 0);

        pkt_words = '{16'hFFFF, 16'h0001};
        runPacket("wrap", 0, 0);

        pkt_words = '{16'h00FF, 16'h0F00, 16'h7000};
        runPacket("stall", 0, 5);

        pkt_words = {};
        for (int i = 0; i < 300; i++) pkt_words.push_back(16'hFFFF);
        runPacket("saturate", 0, 0);

        // Partial packet discarded by reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h4000;
            in_last  = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 checkOutput("midreset_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        pkt_words = '{16'h0005};
        runPacket("after_reset", 0, 0);

        pkt_words = '{16'h0001, 16'h0002, 16'h0003};
        runPacket("gaps", 2, 0);

        // Reset while a result is pending drops it without a clock edge.
        pkt_words = '{16'h8000, 16'h8000};
        modelPacket();
        applyStimulus(0);
        checkOutput("hold_reset_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1 checkOutput("hold_reset_valid", out_valid, 0);
        checkOutput("hold_reset_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 25; n++) begin
            int len;
            len = $urandom_range(1, 6);
            pkt_words = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) pkt_words.push_back(16'($urandom_range(16'hF000, 16'hFFFF)));
                else pkt_words.push_back(16'($urandom()));
            end
            runPacket("random", $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
